// File: rtl/gcd_requester.sv
// ============================================================================
//  Module   : gcd_requester
//  Purpose  : Host-side initiator for a GCD core. Queues operand pairs, issues
//             them one at a time, returns results with latency and timeout.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gcd_requester #(
    parameter int W       = 16,
    parameter int DEPTH   = 4,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [W-1:0]  cmd_a,
    input  logic [W-1:0]  cmd_b,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic [CW-1:0] res_cycles,
    output logic          res_timeout,
    output logic [W-1:0]  operand_A,
    output logic [W-1:0]  operand_B,
    output logic          input_available,
    input  logic          result_rdy,
    input  logic [W-1:0]  result_data,
    output logic          result_taken,
    output logic [1:0]    state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_TAKE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Command FIFO
    logic [W-1:0]  r_mem_a [DEPTH];
    logic [W-1:0]  r_mem_b [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [W-1:0]  w_head_a;
    logic [W-1:0]  w_head_b;
    logic          w_head_zero;

    // Result slot and control
    logic          r_res_valid;
    logic [W-1:0]  r_res_data;
    logic [CW-1:0] r_res_cycles;
    logic          r_res_timeout;
    logic [W-1:0]  r_operand_a;
    logic [W-1:0]  r_operand_b;
    logic          r_input_available;
    logic          r_result_taken;
    logic [CW-1:0] r_wait_cnt;

    logic          w_slot_free;
    logic [CW-1:0] w_cnt_plus;
    logic          w_local;
    logic          w_issue;
    logic          w_capture;
    logic          w_timeout;
    logic          w_cnt_clear;
    logic          w_cnt_inc;

    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign cmd_ready   = !w_full && !reset;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_head_a    = r_mem_a[r_rd_ptr];
    assign w_head_b    = r_mem_b[r_rd_ptr];
    assign w_head_zero = (w_head_a == '0) || (w_head_b == '0);
    assign w_slot_free = !r_res_valid || res_ready;
    assign w_cnt_plus  = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= cmd_a;
            r_mem_b[r_wr_ptr] <= cmd_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_local     = 1'b0;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head_zero) begin
                        if (w_slot_free) begin
                            w_pop   = 1'b1;
                            w_local = 1'b1;
                        end
                    end else begin
                        w_issue = 1'b1;
                        w_next  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_pop       = 1'b1;
                w_cnt_clear = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                // A ready core result with a busy slot freezes the counter.
                if (result_rdy) begin
                    if (w_slot_free) begin
                        w_capture = 1'b1;
                        w_next    = S_TAKE;
                    end
                end else if (w_cnt_plus >= c_timeout) begin
                    if (w_slot_free) begin
                        w_timeout = 1'b1;
                        w_next    = S_IDLE;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_TAKE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_input_available <= 1'b0;
            r_result_taken    <= 1'b0;
            r_operand_a       <= '0;
            r_operand_b       <= '0;
            r_wait_cnt        <= '0;
            r_res_valid       <= 1'b0;
            r_res_data        <= '0;
            r_res_cycles      <= '0;
            r_res_timeout     <= 1'b0;
        end else begin
            r_state           <= w_next;
            r_input_available <= w_issue;
            r_result_taken    <= w_capture;

            // Operands are latched on entry to ISSUE so they are valid with the strobe.
            if (w_issue) begin
                r_operand_a <= w_head_a;
                r_operand_b <= w_head_b;
            end

            if (w_cnt_clear)    r_wait_cnt <= '0;
            else if (w_cnt_inc) r_wait_cnt <= w_cnt_plus;

            if (w_local) begin
                // With one operand zero the answer is the other one (OR of both).
                r_res_valid   <= 1'b1;
                r_res_data    <= w_head_a | w_head_b;
                r_res_cycles  <= '0;
                r_res_timeout <= 1'b0;
            end else if (w_capture) begin
                r_res_valid   <= 1'b1;
                r_res_data    <= result_data;
                r_res_cycles  <= w_cnt_plus;
                r_res_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_res_valid   <= 1'b1;
                r_res_data    <= '0;
                r_res_cycles  <= c_timeout;
                r_res_timeout <= 1'b1;
            end else if (res_ready) begin
                r_res_valid   <= 1'b0;
            end
        end
    end

    assign res_valid       = r_res_valid;
    assign res_data        = r_res_data;
    assign res_cycles      = r_res_cycles;
    assign res_timeout     = r_res_timeout;
    assign operand_A       = r_operand_a;
    assign operand_B       = r_operand_b;
    assign input_available = r_input_available;
    assign result_taken    = r_result_taken;
    assign state           = r_state;

endmodule

`default_nettype wire

// File: tb/tb_gcd_requester.sv
// ============================================================================
//  Module   : tb_gcd_requester
//  Purpose  : Self-checking bench for gcd_requester with a GCD core responder
//             and a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gcd_requester;

    localparam int W       = 16;
    localparam int DEPTH   = 4;
    localparam int CW      = 16;
    localparam int TIMEOUT = 50;
    localparam int NEVER   = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;
    logic [CW-1:0] res_cycles;
    logic          res_timeout;
    logic [W-1:0]  operand_A;
    logic [W-1:0]  operand_B;
    logic          input_available;
    logic          result_rdy = 1'b0;
    logic [W-1:0]  result_data = '0;
    logic          result_taken;
    logic [1:0]    state;

    logic [3*W+CW+6:0] all_outs;
    assign all_outs = {cmd_ready, res_valid, res_data, res_cycles, res_timeout,
                       operand_A, operand_B, input_available, result_taken, state};

    always #5 clk = ~clk;

    gcd_requester #(.W(W), .DEPTH(DEPTH), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cycles(res_cycles), .res_timeout(res_timeout),
        .operand_A(operand_A), .operand_B(operand_B), .input_available(input_available),
        .result_rdy(result_rdy), .result_data(result_data), .result_taken(result_taken),
        .state(state)
    );

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; int lat; } iss_t;
    typedef struct { logic [W-1:0] data; logic [CW-1:0] cycles; logic to; } res_t;

    iss_t iss_q[$];
    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   bp_mode = 0;
    int   issue_count = 0;
    logic core_busy = 1'b0;
    logic prev_taken = 1'b0;
    int   core_cnt = 0;
    int   core_lat = 0;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // GCD core responder: answers each issue after its scripted latency.
    always @(posedge clk) begin : core_model
        iss_t e;
        #1;
        if (reset) begin
            result_rdy = 1'b0;
            core_busy  = 1'b0;
            prev_taken = 1'b0;
        end else begin
            if (result_taken) begin
                checks++;
                assert (prev_taken === 1'b0 && result_rdy === 1'b1) else begin
                    errors++;
                    $error("FAIL taken_pulse: prev_taken %0b result_rdy %0b, required 0 and 1",
                           prev_taken, result_rdy);
                end
                result_rdy = 1'b0;
                core_busy  = 1'b0;
            end
            prev_taken = result_taken;
            if (input_available) begin
                issue_count++;
                checks++;
                assert (!(core_busy && core_lat < TIMEOUT)) else begin
                    errors++;
                    $error("FAIL overlap_issue: issue while core busy, required no issue");
                end
                checks++;
                assert (iss_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_issue: operands %0d,%0d, required no issue",
                           operand_A, operand_B);
                end
                if (iss_q.size() != 0) begin
                    e = iss_q.pop_front();
                    checks++;
                    assert ({operand_A, operand_B} === {e.a, e.b}) else begin
                        errors++;
                        $error("FAIL operands: observed %0d,%0d required %0d,%0d",
                               operand_A, operand_B, e.a, e.b);
                    end
                    core_busy   = 1'b1;
                    core_lat    = e.lat;
                    core_cnt    = e.lat;
                    result_rdy  = 1'b0;
                    result_data = gcd_ref(e.a, e.b);
                end
            end else if (core_busy && !result_rdy && core_lat < TIMEOUT) begin
                core_cnt--;
                if (core_cnt == 0) result_rdy = 1'b1;
            end
        end
    end

    always @(posedge clk) begin : host_ready
        #1;
        case (bp_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = ($urandom_range(0, 2) != 0);
            default: res_ready = 1'b0;
        endcase
    end

    // Scoreboard: every host handshake must match the next expected result.
    always @(negedge clk) begin : result_monitor
        res_t e;
        if (!reset && res_valid && res_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result: data %0d cycles %0d to %0b, required none",
                       res_data, res_cycles, res_timeout);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({res_data, res_cycles, res_timeout} === {e.data, e.cycles, e.to}) else begin
                    errors++;
                    $error("FAIL result: observed data %0d cycles %0d to %0b, required data %0d cycles %0d to %0b",
                           res_data, res_cycles, res_timeout, e.data, e.cycles, e.to);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        output int waits);
        iss_t it;
        res_t r;
        waits     = 0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && waits < 2000) begin
            @(posedge clk);
            #1;
            waits++;
        end
        checks++;
        assert (waits < 2000) else begin
            errors++;
            $error("FAIL push_wait: waited %0d cycles, required under 2000", waits);
        end
        if (waits < 2000) begin
            @(posedge clk);
            if (a == 0 || b == 0) begin
                r.data   = a | b;
                r.cycles = '0;
                r.to     = 1'b0;
            end else begin
                it.a   = a;
                it.b   = b;
                it.lat = lat;
                iss_q.push_back(it);
                if (lat >= TIMEOUT) begin
                    r.data   = '0;
                    r.cycles = CW'(TIMEOUT);
                    r.to     = 1'b1;
                end else begin
                    r.data   = gcd_ref(a, b);
                    r.cycles = CW'(lat);
                    r.to     = 1'b0;
                end
            end
            exp_q.push_back(r);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            idle(1);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain: %0d results outstanding, required 0", tag, exp_q.size());
        end
        idle(2);
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int n;
        n = 0;
        while (state !== s && n < 500) begin
            idle(1);
            n++;
        end
        checks++;
        assert (state === s) else begin
            errors++;
            $error("FAIL %s_state: observed %0d required %0d", tag, state, s);
        end
    endtask

    initial begin : stimulus
        int w;
        int n;
        int c0;
        logic [W-1:0] ra, rb;
        int rl;
        logic [W-1:0] burst_a [5];
        logic [W-1:0] burst_b [5];

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        idle(3);

        // Reset state
        checks++;
        assert (all_outs === '0) else begin
            errors++;
            $error("FAIL reset_outputs: observed %h required 0", all_outs);
        end
        reset = 1'b0;
        idle(1);
        checks++;
        assert ({cmd_ready, state} === {1'b1, 2'd0}) else begin
            errors++;
            $error("FAIL after_reset: cmd_ready %0b state %0d, required 1 and 0", cmd_ready, state);
        end

        // Single request
        c0 = issue_count;
        push(16'd270, 16'd192, 20, w);
        drain("single");
        checks++;
        assert (issue_count - c0 === 1) else begin
            errors++;
            $error("FAIL single_issues: observed %0d required 1", issue_count - c0);
        end

        // Burst: a long request keeps the core busy so the FIFO fills
        push(16'd3, 16'd5, 40, w);
        wait_state(2'd2, "burst_pre");
        burst_a[0] = 16'd12;  burst_b[0] = 16'd18;
        burst_a[1] = 16'd17;  burst_b[1] = 16'd5;
        burst_a[2] = 16'd100; burst_b[2] = 16'd75;
        burst_a[3] = 16'd1;   burst_b[3] = 16'd1;
        burst_a[4] = 16'd48;  burst_b[4] = 16'd36;
        for (int i = 0; i < 5; i++) begin
            push(burst_a[i], burst_b[i], 3, w);
            checks++;
            assert ((w > 0) === (i == 4)) else begin
                errors++;
                $error("FAIL burst_ready%0d: waited %0d cycles, required %s", i, w,
                       (i == 4) ? "a stall" : "no stall");
            end
        end
        drain("burst");

        // Zero operands: answered locally
        c0 = issue_count;
        push(16'd0, 16'd9, 0, w);
        push(16'd7, 16'd0, 0, w);
        push(16'd0, 16'd0, 0, w);
        drain("zero");
        checks++;
        assert (issue_count === c0) else begin
            errors++;
            $error("FAIL zero_issues: observed %0d required 0", issue_count - c0);
        end

        // Back-pressure
        bp_mode = 2;
        idle(1);
        push(16'd0, 16'd5, 0, w);
        push(16'd21, 16'd14, 5, w);
        n = 0;
        while (!result_rdy && n < 200) begin
            idle(1);
            n++;
        end
        idle(10);
        checks++;
        assert ({result_rdy, state, result_taken, res_valid} === {1'b1, 2'd2, 1'b0, 1'b1}) else begin
            errors++;
            $error("FAIL backpressure: rdy %0b state %0d taken %0b valid %0b, required 1 2 0 1",
                   result_rdy, state, result_taken, res_valid);
        end
        bp_mode = 0;
        drain("backpressure");

        // Timeout
        push(16'd9, 16'd6, NEVER, w);
        n = 0;
        while (!input_available && n < 100) begin
            idle(1);
            n++;
        end
        idle(1);
        n = 0;
        while (!res_valid && n < 200) begin
            idle(1);
            n++;
        end
        checks++;
        assert (n === TIMEOUT) else begin
            errors++;
            $error("FAIL timeout_latency: observed %0d cycles required %0d", n, TIMEOUT);
        end
        push(16'd8, 16'd4, 3, w);
        drain("timeout");

        // Reset mid-WAIT with two pairs queued
        push(16'd10, 16'd4, 30, w);
        wait_state(2'd2, "reset_pre");
        push(16'd6, 16'd9, 5, w);
        push(16'd0, 16'd3, 0, w);
        reset = 1'b1;
        idle(1);
        checks++;
        assert (all_outs === '0) else begin
            errors++;
            $error("FAIL reset_mid: observed %h required 0", all_outs);
        end
        iss_q.delete();
        exp_q.delete();
        idle(2);
        reset = 1'b0;
        idle(1);
        checks++;
        assert ({cmd_ready, state} === {1'b1, 2'd0}) else begin
            errors++;
            $error("FAIL reset_mid_after: cmd_ready %0b state %0d, required 1 and 0", cmd_ready, state);
        end
        c0 = issue_count;
        idle(60);
        checks++;
        assert ({issue_count, res_valid} === {c0, 1'b0}) else begin
            errors++;
            $error("FAIL reset_stale: issues %0d res_valid %0b, required 0 and 0",
                   issue_count - c0, res_valid);
        end

        // Randomized traffic with random back-pressure
        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 4) == 0) ? 16'd0 : W'($urandom_range(1, 600));
            rb = ($urandom_range(0, 4) == 0) ? 16'd0 : W'($urandom_range(1, 600));
            rl = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 30);
            push(ra, rb, rl, w);
            idle($urandom_range(0, 3));
        end
        bp_mode = 0;
        drain("random");
        checks++;
        assert (iss_q.size() === 0) else begin
            errors++;
            $error("FAIL random_issue_q: %0d pairs never issued, required 0", iss_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
